// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divider_pkg;

  localparam int          DIV_DATA_W    = 16;
  localparam logic [15:0] DIV_RD_BASE   = 16'd64;
  localparam logic [15:0] DIV_WR_BASE   = 16'd0;
  localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CALC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference if it did not go negative.
module divider_step
  import divider_pkg::*;
#(
  parameter int W = DIV_DATA_W
) (
  input  logic [W:0]   r,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W:0]   r_next,
  output logic [W-1:0] q_next
);

  logic [W+1:0] t;
  logic [W+1:0] d_ext;

  always_comb begin
    // r[W] is always 0 while R < D; widening keeps the compare exact regardless.
    t     = {r, q[W-1]};
    d_ext = {2'b00, d};
    if (t >= d_ext) begin
      r_next = (W+1)'(t - d_ext);
      q_next = {q[W-2:0], 1'b1};
    end else begin
      r_next = (W+1)'(t);
      q_next = {q[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_core.sv
// 16-cycle restoring divider fed by the scratch-memory read controller.
// Handshake: sc_mem_rd_en is accepted only in IDLE; div_done releases the controller.
module divider_core
  import divider_pkg::*;
#(
  parameter int          DATA_W  = DIV_DATA_W,
  parameter logic [15:0] RD_BASE = DIV_RD_BASE,
  parameter logic [15:0] WR_BASE = DIV_WR_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sc_mem_rd_en,
  input  logic [15:0]           sc_mem_rdaddr,
  input  logic [2*DATA_W-1:0]   sc_mem_rddata,
  output logic                  res_mem_wr_en,
  output logic [15:0]           res_mem_wraddr,
  output logic [2*DATA_W-1:0]   res_mem_wrdata,
  output logic                  div_by_zero,
  output logic                  div_done,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  state_t              state, state_next;
  logic [15:0]         rdaddr_q;
  logic [DATA_W-1:0]   q_reg, d_reg;
  logic [DATA_W:0]     r_reg;
  logic [3:0]          cnt;
  logic [DATA_W:0]     r_nxt;
  logic [DATA_W-1:0]   q_nxt;
  logic [DATA_W-1:0]   dividend, divisor;
  logic [15:0]         wraddr_map;

  assign dividend   = sc_mem_rddata[2*DATA_W-1:DATA_W];
  assign divisor    = sc_mem_rddata[DATA_W-1:0];
  assign wraddr_map = WR_BASE + ((rdaddr_q - RD_BASE) >> 1);
  assign fsm_state  = state;

  divider_step #(.W(DATA_W)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_nxt),
    .q_next (q_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (sc_mem_rd_en) state_next = ST_LOAD;
      ST_LOAD:  state_next = (divisor == '0) ? ST_WRITE : ST_CALC;
      ST_CALC:  if (cnt == 4'd0) state_next = ST_WRITE;
      ST_WRITE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdaddr_q       <= '0;
      q_reg          <= '0;
      d_reg          <= '0;
      r_reg          <= '0;
      cnt            <= '0;
      res_mem_wr_en  <= 1'b0;
      res_mem_wraddr <= '0;
      res_mem_wrdata <= '0;
      div_by_zero    <= 1'b0;
      div_done       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (sc_mem_rd_en) rdaddr_q <= sc_mem_rdaddr;
        end
        ST_LOAD: begin
          q_reg <= dividend;
          d_reg <= divisor;
          r_reg <= '0;
          cnt   <= 4'(DATA_W - 1);
          if (divisor == '0) begin
            res_mem_wr_en  <= 1'b1;
            div_done       <= 1'b1;
            div_by_zero    <= 1'b1;
            res_mem_wraddr <= wraddr_map;
            res_mem_wrdata <= {DATA_W'(DIV_ZERO_QUOT), dividend};
          end
        end
        ST_CALC: begin
          r_reg <= r_nxt;
          q_reg <= q_nxt;
          // The final step's result goes straight into the output registers.
          if (cnt == 4'd0) begin
            res_mem_wr_en  <= 1'b1;
            div_done       <= 1'b1;
            div_by_zero    <= 1'b0;
            res_mem_wraddr <= wraddr_map;
            res_mem_wrdata <= {q_nxt, r_nxt[DATA_W-1:0]};
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WRITE: begin
          res_mem_wr_en <= 1'b0;
          div_done      <= 1'b0;
          div_by_zero   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_core.sv
// Directed bench for divider_core: latency, results, zero divide, ignored strobes, reset abort.
module tb_divider_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        sc_mem_rd_en;
  logic [15:0] sc_mem_rdaddr;
  logic [31:0] sc_mem_rddata;
  logic        res_mem_wr_en;
  logic [15:0] res_mem_wraddr;
  logic [31:0] res_mem_wrdata;
  logic        div_by_zero;
  logic        div_done;
  logic        busy;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [47:0] exp_q[$];

  int          lat;
  logic [15:0] wa;
  logic [31:0] wd;
  logic        dbz, dn, bz, pa, ba;

  divider_core dut (
    .clk            (clk),
    .reset          (reset),
    .sc_mem_rd_en   (sc_mem_rd_en),
    .sc_mem_rdaddr  (sc_mem_rdaddr),
    .sc_mem_rddata  (sc_mem_rddata),
    .res_mem_wr_en  (res_mem_wr_en),
    .res_mem_wraddr (res_mem_wraddr),
    .res_mem_wrdata (res_mem_wrdata),
    .div_by_zero    (div_by_zero),
    .div_done       (div_done),
    .busy           (busy),
    .fsm_state      (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Drives rd_en in cycle N and the operand word in cycle N+1; returns at negedge of N+1.
  task automatic issue(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    sc_mem_rd_en  = 1'b1;
    sc_mem_rdaddr = addr;
    sc_mem_rddata = 32'h0;
    @(negedge clk);
    sc_mem_rd_en  = 1'b0;
    sc_mem_rddata = data;
  endtask

  // Issues one operation and reports the cycle offset (from N) at which the write appeared.
  task automatic run_op(input logic [15:0] addr, input logic [31:0] data,
                        output int o_lat, output logic [15:0] o_wa, output logic [31:0] o_wd,
                        output logic o_dbz, output logic o_dn, output logic o_bz,
                        output logic o_pa, output logic o_ba);
    issue(addr, data);
    o_lat = -1; o_wa = '0; o_wd = '0; o_dbz = 1'b0; o_dn = 1'b0; o_bz = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (res_mem_wr_en === 1'b1) begin
        o_lat = c; o_wa = res_mem_wraddr; o_wd = res_mem_wrdata;
        o_dbz = div_by_zero; o_dn = div_done; o_bz = busy;
        break;
      end
      @(negedge clk);
      sc_mem_rddata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    o_pa = res_mem_wr_en | div_done | div_by_zero;
    o_ba = busy;
  endtask

  task automatic test_reset();
    reset = 1'b0; sc_mem_rd_en = 1'b0; sc_mem_rdaddr = '0; sc_mem_rddata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({res_mem_wr_en, res_mem_wraddr, res_mem_wrdata, div_by_zero, div_done, busy} !== 52'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr_en=%b wraddr=%h wrdata=%h dbz=%b done=%b busy=%b, want all 0",
               res_mem_wr_en, res_mem_wraddr, res_mem_wrdata, div_by_zero, div_done, busy);
    end
    n_checks++;
    if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_divide();
    run_op(16'd64, {16'd100, 16'd7}, lat, wa, wd, dbz, dn, bz, pa, ba);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL basic_latency: got %0d want 18", lat); end
    n_checks++; if (wa !== 16'd0) begin n_fail++; $display("FAIL basic_wraddr: got %h want 0000", wa); end
    n_checks++; if (wd !== 32'h000E_0002) begin n_fail++; $display("FAIL basic_wrdata: got %h want 000e0002", wd); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", dbz); end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", dn); end
    n_checks++; if (bz !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_write: got %b want 1", bz); end
    n_checks++; if (pa !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: strobes still high, got %b want 0", pa); end
    n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", ba); end
  endtask

  task automatic test_max_dividend();
    run_op(16'd190, {16'hFFFF, 16'd1}, lat, wa, wd, dbz, dn, bz, pa, ba);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL max_latency: got %0d want 18", lat); end
    n_checks++; if (wa !== 16'd63) begin n_fail++; $display("FAIL max_wraddr: got %0d want 63", wa); end
    n_checks++; if (wd !== 32'hFFFF_0000) begin n_fail++; $display("FAIL max_wrdata: got %h want ffff0000", wd); end
  endtask

  task automatic test_div_zero();
    run_op(16'd70, {16'd5, 16'd0}, lat, wa, wd, dbz, dn, bz, pa, ba);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL zero_latency: got %0d want 2", lat); end
    n_checks++; if (wd !== 32'hFFFF_0005) begin n_fail++; $display("FAIL zero_wrdata: got %h want ffff0005", wd); end
    n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL zero_dbz: got %b want 1", dbz); end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", dn); end
    n_checks++; if (wa !== 16'd3) begin n_fail++; $display("FAIL zero_wraddr: got %0d want 3", wa); end
    n_checks++; if (pa !== 1'b0) begin n_fail++; $display("FAIL zero_pulse_width: got %b want 0", pa); end
  endtask

  task automatic test_corner_values();
    logic [15:0] t_addr[6] = '{16'd66, 16'd68, 16'd72, 16'd74, 16'd62, 16'd76};
    logic [31:0] t_data[6] = '{{16'd3, 16'd10}, {16'hFFFF, 16'hFFFF}, {16'd0, 16'd9},
                               {16'hFFFF, 16'h8001}, {16'd100, 16'd7}, {16'd0, 16'd0}};
    logic [15:0] t_wa[6]   = '{16'd1, 16'd2, 16'd4, 16'd5, 16'h7FFF, 16'd6};
    logic [31:0] t_wd[6]   = '{32'h0000_0003, 32'h0001_0000, 32'h0000_0000,
                               32'h0001_7FFE, 32'h000E_0002, 32'hFFFF_0000};
    logic        t_dbz[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          t_lat[6]  = '{18, 18, 18, 18, 18, 2};
    for (int i = 0; i < 6; i++) begin
      run_op(t_addr[i], t_data[i], lat, wa, wd, dbz, dn, bz, pa, ba);
      n_checks++;
      if (lat !== t_lat[i]) begin n_fail++; $display("FAIL corner%0d_latency: got %0d want %0d", i, lat, t_lat[i]); end
      n_checks++;
      if ({wa, wd, dbz} !== {t_wa[i], t_wd[i], t_dbz[i]}) begin
        n_fail++;
        $display("FAIL corner%0d_result: got wraddr=%h wrdata=%h dbz=%b want wraddr=%h wrdata=%h dbz=%b",
                 i, wa, wd, dbz, t_wa[i], t_wd[i], t_dbz[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    issue(16'd100, {16'd1000, 16'd3});
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({res_mem_wr_en, div_done, div_by_zero, busy, fsm_state, res_mem_wraddr, res_mem_wrdata} !== 54'h0) begin
      n_fail++;
      $display("FAIL midreset_clear: got wr_en=%b done=%b dbz=%b busy=%b state=%0d wraddr=%h wrdata=%h, want all 0",
               res_mem_wr_en, div_done, div_by_zero, busy, fsm_state, res_mem_wraddr, res_mem_wrdata);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ((res_mem_wr_en | div_done | busy) !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: got wr_en=%b done=%b busy=%b want 0", res_mem_wr_en, div_done, busy);
    end
    run_op(16'd80, {16'd50, 16'd6}, lat, wa, wd, dbz, dn, bz, pa, ba);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL midreset_next_latency: got %0d want 18", lat); end
    n_checks++;
    if ({wa, wd} !== {16'd8, 32'h0008_0002}) begin
      n_fail++; $display("FAIL midreset_next_result: got %h/%h want 0008/00080002", wa, wd);
    end
  endtask

  task automatic test_ignored_rd_en();
    int writes;
    issue(16'd96, {16'd200, 16'd9});
    repeat (4) @(negedge clk);
    sc_mem_rd_en = 1'b1; sc_mem_rdaddr = 16'd130; sc_mem_rddata = {16'd9, 16'd2};
    @(negedge clk);
    sc_mem_rd_en = 1'b0; sc_mem_rddata = 32'hDEAD_BEEF;
    lat = -1;
    for (int c = 6; c <= 40; c++) begin
      if (res_mem_wr_en === 1'b1) begin lat = c; wa = res_mem_wraddr; wd = res_mem_wrdata; break; end
      @(negedge clk);
    end
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL ignore_latency: got %0d want 18", lat); end
    n_checks++;
    if ({wa, wd} !== {16'd16, 32'h0016_0002}) begin
      n_fail++; $display("FAIL ignore_result: got %h/%h want 0010/00160002", wa, wd);
    end
    // A strobe during the WRITE cycle must also be dropped.
    sc_mem_rd_en = 1'b1; sc_mem_rdaddr = 16'd132; sc_mem_rddata = {16'd8, 16'd3};
    @(negedge clk);
    sc_mem_rd_en = 1'b0;
    writes = 0;
    for (int c = 0; c < 30; c++) begin
      if (res_mem_wr_en === 1'b1) writes++;
      @(negedge clk);
    end
    n_checks++; if (writes !== 0) begin n_fail++; $display("FAIL ignore_extra_writes: got %0d want 0", writes); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] dvd, dvs;
    logic [47:0] e;
    for (int i = 0; i < 32; i++) begin
      dvd = 16'(i * 2053 + 17);
      dvs = 16'(i * 37 + 1);
      exp_q.push_back({16'(i), dvd / dvs, dvd % dvs});
      run_op(16'(64 + 2 * i), {dvd, dvs}, lat, wa, wd, dbz, dn, bz, pa, ba);
      e = exp_q.pop_front();
      n_checks++;
      if (lat !== 18) begin n_fail++; $display("FAIL b2b%0d_latency: got %0d want 18", i, lat); end
      n_checks++;
      if ({wa, wd} !== e) begin
        n_fail++; $display("FAIL b2b%0d_result: got %h/%h want %h/%h", i, wa, wd, e[47:32], e[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_divide();
    test_max_dividend();
    test_div_zero();
    test_corner_values();
    test_reset_mid_op();
    test_ignored_rd_en();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_core.md
# divider_core

Iterative 16-bit restoring divider that sits directly downstream of the divider scratch-memory read controller. It captures one operand word from scratch memory one cycle after each read strobe and computes quotient and remainder over 16 cycles. It writes the result to result memory and pulses `div_done`, which releases the read controller to issue the next read.

## Interface
Parameters:
- `DATA_W`, 16: operand, quotient and remainder width.
- `RD_BASE`, 16'd64: first scratch-memory read address, used for write-address mapping.
- `WR_BASE`, 16'd0: first result-memory write address.

Ports:
- `clk`, in, 1: single clock. All state is updated on its rising edge.
- `reset`, in, 1: asynchronous, active-low. Assertion clears all state immediately. Deassertion is synchronous to `clk` at system level.
- `sc_mem_rd_en`, in, 1: read strobe from the read controller. Operand data is valid on the following cycle.
- `sc_mem_rdaddr`, in, 16: read address, valid with `sc_mem_rd_en`.
- `sc_mem_rddata`, in, 32: `[31:16]` is the dividend and `[15:0]` is the divisor. Valid one cycle after `sc_mem_rd_en`.
- `res_mem_wr_en`, out, 1: one-cycle write strobe.
- `res_mem_wraddr`, out, 16: result address.
- `res_mem_wrdata`, out, 32: `[31:16]` is the quotient and `[15:0]` is the remainder.
- `div_by_zero`, out, 1: qualifies the current write. Asserted together with `res_mem_wr_en`.
- `div_done`, out, 1: one-cycle pulse, coincident with `res_mem_wr_en`.
- `busy`, out, 1: high from LOAD through WRITE inclusive.

## Operation
Reset values: all outputs are 0, the FSM is in IDLE, and the iteration counter is 0.

FSM states:
- IDLE: on `sc_mem_rd_en`, latch `sc_mem_rdaddr` and go to LOAD.
- LOAD: capture the dividend into Q and the divisor into D, and clear the 17-bit partial remainder R.
  - If D == 0, go to WRITE with the zero-divide result.
  - Otherwise set the counter to 15 and go to CALC.
- CALC: perform one restoring step per cycle.
  - T = {R[15:0], Q[15]}.
  - If T >= {1'b0, D}: R = T − D and Q = {Q[14:0], 1}. Otherwise R = T and Q = {Q[14:0], 0}.
  - When the counter reaches 0, go to WRITE. Otherwise decrement the counter.
- WRITE: drive `res_mem_wr_en`, `div_done` and the write data/address for exactly one cycle, then go to IDLE.

Write data:
- Normal case: `res_mem_wrdata` = {Q, R[15:0]}.
- Zero-divide case: quotient is 16'hFFFF, remainder is the dividend, and `div_by_zero` = 1.

Address mapping:
- `res_mem_wraddr` = WR_BASE + ((latched rdaddr − RD_BASE) >> 1), computed modulo 2^16.
- Example: 64→0, 66→1, 190→63.

Arithmetic rules:
- The compare and subtract are 17 bits wide and unsigned.
- The remainder is always less than the divisor.
- No rounding is applied.

Boundary conditions:
- `sc_mem_rd_en` while `busy` is ignored: no relatch and no state change. This is a protocol violation; the controller never issues a read before `div_done`.
- `sc_mem_rd_en` in the same cycle as WRITE is ignored. It is accepted from IDLE only.
- Reset asserted mid-operation: immediate return to IDLE. Any pending write is abandoned, and no `div_done` or `res_mem_wr_en` pulse occurs, even on release.
- Dividend < divisor gives Q = 0 and R = dividend.
- Dividend = 0 gives Q = 0 and R = 0.

## Timing
Let `sc_mem_rd_en` be high in cycle N.
- N+1: LOAD. `sc_mem_rddata` is sampled.
- N+2 to N+17: CALC, 16 iterations.
- N+18: WRITE, with registered outputs valid. `div_done` = `res_mem_wr_en` = 1.
- Zero divisor: WRITE occurs at N+2.

Other timing rules:
- The earliest next accepted `sc_mem_rd_en` is N+19.
- With the read controller (done → next read in two cycles), the throughput is 1 result per 21 cycles.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package `divider_pkg` holds:
  - State encodings: IDLE, LOAD, CALC, WRITE.
  - `DATA_W`.
  - `RD_BASE`.
  - `WR_BASE`.
  - The 16'hFFFF zero-divide quotient constant.
- Sub-module `divider_step`: a purely combinational single restoring iteration.
  - Inputs: R, Q, D.
  - Outputs: next R and next Q.
  - It is instantiated once inside the CALC datapath.
- Top-level RTL contains the FSM, the 4-bit counter, the operand registers and the address mapping.

## Test plan
- rdaddr = 64, data {100, 7} → at N+18: wr_en = 1, wraddr = 0, wrdata = {14, 2}, div_by_zero = 0, div_done pulse of 1 cycle.
- rdaddr = 190, data {16'hFFFF, 1} → wraddr = 63, wrdata = {16'hFFFF, 0}.
- Data {5, 0} → at N+2: wrdata = {16'hFFFF, 5}, div_by_zero = 1, div_done = 1.
- Data {3, 10} → wrdata = {0, 3}. Data {16'hFFFF, 16'hFFFF} → wrdata = {1, 0}.
- Reset asserted at N+8 and released at N+10 → all outputs 0 immediately. No wr_en or div_done through N+30. A new rd_en at N+12 gives a correct result at N+30.
- Extra `sc_mem_rd_en` at N+5 → ignored, and the original result is still written at N+18. Separately, run 32 back-to-back reads at addresses 64..126 with the read controller → 32 writes to addresses 0..31, each matching the reference model.
